seq_fix_mul: RTL and testbench

- Iterative shift-add fixed-point multiplier that sits directly downstream of, and drives, the existing `mul_shift` datapath step.
- Each cycle it feeds one multiplier bit plus the current shifted multiplicand into `mul_shift`. It accumulates `O_OUT` and recirculates `O_SFT1`.
- After D_W iterations it applies sign, rescales to Q(D_W-FRAC).FRAC, saturates and presents the result.
- It is used by the attention datapath wherever one scalar product per D_W+3 cycles is sufficient.

---
 rtl/mha_fix_pkg.sv | 24 ++
 rtl/mul_shift.sv | 15 +
 rtl/seq_fix_mul.sv | 119 +++++++++++
 tb/tb_seq_fix_mul.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mha_fix_pkg.sv
// Shared definitions for the attention fixed-point arithmetic blocks:
// the sequencer state set, default widths and Q-format saturation limits.
package mha_fix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int D_W_DEF  = 16;
  localparam int FRAC_DEF = 8;

  // Limits of a signed w-bit result.
  function automatic longint q_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint q_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mul_shift.sv
// One shift-add step: passes the multiplicand through when the multiplier
// bit is set, and offers the multiplicand shifted left by one for the next step.
module mul_shift #(
  parameter int D_W = 16
) (
  input  logic [2*D_W-1:0] I_IN1,
  input  logic             I_IN2,
  output logic [2*D_W-1:0] O_OUT,
  output logic [2*D_W-1:0] O_SFT1
);

  assign O_OUT  = I_IN2 ? I_IN1 : '0;
  assign O_SFT1 = {I_IN1[2*D_W-2:0], 1'b0};

endmodule

// File: rtl/seq_fix_mul.sv
// Iterative signed fixed-point multiplier: magnitudes are multiplied by
// shift-add over D_W cycles, then sign-fixed, rescaled and saturated.
//
// state | meaning
// IDLE  | waiting for I_START; O_VLD pulse is seen here after DONE
// CALC  | one shift-add iteration per cycle, D_W iterations
// SIGN  | apply the result sign to the accumulator
// DONE  | rescale, saturate and register the result, raise O_VLD
module seq_fix_mul
  import mha_fix_pkg::*;
#(
  parameter int D_W  = D_W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_START,
  input  logic [D_W-1:0]     I_A,
  input  logic [D_W-1:0]     I_B,
  output logic               O_BUSY,
  output logic               O_VLD,
  output logic [D_W-1:0]     O_PROD,
  output logic [2*D_W-1:0]   O_PROD_FULL,
  output logic               O_SAT
);

  localparam int CW = $clog2(D_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(D_W - 1);
  localparam logic signed [2*D_W-1:0] SAT_MAX = (2*D_W)'(q_max(D_W));
  localparam logic signed [2*D_W-1:0] SAT_MIN = (2*D_W)'(q_min(D_W));
  localparam logic [D_W-1:0] PROD_MAX = SAT_MAX[D_W-1:0];
  localparam logic [D_W-1:0] PROD_MIN = SAT_MIN[D_W-1:0];

  state_t             state;
  logic [2*D_W-1:0]   mcand;
  logic [2*D_W-1:0]   acc;
  logic [D_W-1:0]     mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [2*D_W-1:0]   step_out;
  logic [2*D_W-1:0]   step_sft;
  logic [D_W-1:0]     abs_a;
  logic [D_W-1:0]     abs_b;
  logic signed [2*D_W-1:0] acc_s;
  logic signed [2*D_W-1:0] r;
  logic               sat_hi;
  logic               sat_lo;

  mul_shift #(.D_W(D_W)) u_mul_shift (
    .I_IN1  (mcand),
    .I_IN2  (mplier[0]),
    .O_OUT  (step_out),
    .O_SFT1 (step_sft)
  );

  // Unsigned magnitude: the most-negative value maps onto itself as unsigned.
  assign abs_a  = I_A[D_W-1] ? (~I_A + 1'b1) : I_A;
  assign abs_b  = I_B[D_W-1] ? (~I_B + 1'b1) : I_B;

  assign acc_s  = acc;
  assign r      = acc_s >>> FRAC;
  assign sat_hi = (r > SAT_MAX);
  assign sat_lo = (r < SAT_MIN);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= IDLE;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      O_BUSY      <= 1'b0;
      O_VLD       <= 1'b0;
      O_PROD      <= '0;
      O_PROD_FULL <= '0;
      O_SAT       <= 1'b0;
    end else begin
      O_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (I_START) begin
            mcand  <= {{D_W{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= I_A[D_W-1] ^ I_B[D_W-1];
            acc    <= '0;
            cnt    <= '0;
            O_BUSY <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc + step_out;
          mcand  <= step_sft;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= SIGN;
        end
        SIGN: begin
          if (neg) acc <= -acc;
          state <= DONE;
        end
        DONE: begin
          O_PROD_FULL <= acc;
          if (sat_hi)      O_PROD <= PROD_MAX;
          else if (sat_lo) O_PROD <= PROD_MIN;
          else             O_PROD <= r[D_W-1:0];
          O_SAT  <= sat_hi | sat_lo;
          O_VLD  <= 1'b1;
          O_BUSY <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fix_mul.sv
// Directed bench for seq_fix_mul: table of hand-computed products plus
// sequences for start-while-busy and mid-operation reset.
module tb_seq_fix_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        vld;
  logic [15:0] prod;
  logic [31:0] prod_full;
  logic        sat;

  int checks;
  int errors;

  seq_fix_mul #(.D_W(16), .FRAC(8)) dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_START     (start),
    .I_A         (a),
    .I_B         (b),
    .O_BUSY      (busy),
    .O_VLD       (vld),
    .O_PROD      (prod),
    .O_PROD_FULL (prod_full),
    .O_SAT       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] full;
    logic [15:0] prod;
    logic        sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one op at the next edge, scrambles the inputs afterwards and
  // returns the number of edges until O_VLD (0 if it never came).
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        output int lat, output int busy_low);
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va;
    b = ~vb;
    lat = 0;
    busy_low = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (vld) begin
        lat = i;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  int lat;
  int busy_low;
  int vld_cnt;
  int busy_bad;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{16'h0180, 16'h0200, 32'h0003_0000, 16'h0300, 1'b0};
    vecs[1] = '{16'hFE80, 16'h0200, 32'hFFFD_0000, 16'hFD00, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 16'h7FFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 32'h4000_0000, 16'h7FFF, 1'b1};
    vecs[5] = '{16'h8000, 16'h7FFF, 32'hC000_8000, 16'h8000, 1'b1};
    vecs[6] = '{16'h0000, 16'h8000, 32'h0000_0000, 16'h0000, 1'b0};
    vecs[7] = '{16'h0100, 16'hFF00, 32'hFFFF_0000, 16'hFF00, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_prod", {16'd0, prod}, 32'd0);
    chk("rst_full", prod_full, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].a, vecs[v].b, lat, busy_low);
      chk($sformatf("v%0d_latency", v), lat, 32'd18);
      chk($sformatf("v%0d_busy_low", v), busy_low, 32'd0);
      chk($sformatf("v%0d_full", v), prod_full, vecs[v].full);
      chk($sformatf("v%0d_prod", v), {16'd0, prod}, {16'd0, vecs[v].prod});
      chk($sformatf("v%0d_sat", v), {31'd0, sat}, {31'd0, vecs[v].sat});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld_pulse", v), {31'd0, vld}, 32'd0);
      chk($sformatf("v%0d_hold_prod", v), {16'd0, prod}, {16'd0, vecs[v].prod});
    end

    // Start pulses at edges 3 and 18 fall inside the operation and must be dropped.
    @(negedge clk);
    a = 16'h0100;
    b = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    vld_cnt = 0;
    busy_bad = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 18);
      a = 16'h0200;
      @(posedge clk);
      #1;
      if (vld) begin
        vld_cnt++;
        chk("busy_seq_vld_edge", k, 32'd18);
        chk("busy_seq_prod", {16'd0, prod}, 32'h0000_0100);
      end
      if (k <= 17 && !busy) busy_bad++;
    end
    start = 1'b0;
    chk("busy_seq_vld_count", vld_cnt, 32'd1);
    chk("busy_seq_busy_high", busy_bad, 32'd0);
    run_op(16'h0200, 16'h0100, lat, busy_low);
    chk("after_busy_latency", lat, 32'd18);
    chk("after_busy_prod", {16'd0, prod}, 32'h0000_0200);

    // Reset at edge 7 of an op: outputs clear at once, no result appears.
    @(negedge clk);
    a = 16'h0100;
    b = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_vld", {31'd0, vld}, 32'd0);
    chk("midrst_prod", {16'd0, prod}, 32'd0);
    chk("midrst_full", prod_full, 32'd0);
    chk("midrst_sat", {31'd0, sat}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (vld || busy) vld_cnt++;
    end
    chk("midrst_no_vld", vld_cnt, 32'd0);
    run_op(16'h0300, 16'h0080, lat, busy_low);
    chk("post_rst_latency", lat, 32'd18);
    chk("post_rst_prod", {16'd0, prod}, 32'h0000_0180);
    chk("post_rst_full", prod_full, 32'h0001_8000);
    chk("post_rst_sat", {31'd0, sat}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
